// File: rtl/hilo_register.sv
// HI/LO result register behind the 32x32 multiplier: waits out the multiply
// latency, captures the 64-bit product and serves MFHI/MFLO reads.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   signal[2:0]      ALU control code shared with the multiplier
//   dataIn[63:0]     multiplier product, sampled only at the capture edge
//   hiOut, loOut     current HI / LO contents
//   dataOut          registered MFHI/MFLO read result
//   busy             multiply in flight
//   valid            HI/LO hold a completed product
module hilo_register #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [2:0]  SIG_MUL    = 3'b100,
  parameter logic [2:0]  SIG_MFHI   = 3'b101,
  parameter logic [2:0]  SIG_MFLO   = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  signal,
  input  logic [63:0] dataIn,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        valid
);

  localparam int unsigned CW = $clog2(MUL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mul_q, mul_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    dout_q, dout_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  logic is_mul;
  logic is_hi;
  logic is_lo;
  logic start;

  assign is_mul = (signal == SIG_MUL);
  assign is_hi  = (signal == SIG_MFHI);
  assign is_lo  = (signal == SIG_MFLO);
  // Only the rising edge of the multiply code starts a multiply,
  // so a held code is one operation.
  assign start  = is_mul && !mul_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = is_mul;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    valid_d = valid_q;

    case (state_q)
      WAIT: begin
        if (start) begin
          // New multiply supersedes the in-flight one.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          hi_d    = dataIn[63:32];
          lo_d    = dataIn[31:0];
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          unique case (1'b1)
            is_hi:   dout_d = hi_q;
            is_lo:   dout_d = lo_q;
            default: dout_d = dout_q;
          endcase
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign hiOut   = hi_q;
  assign loOut   = lo_q;
  assign dataOut = dout_q;
  assign busy    = busy_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_hilo_register.sv
// Directed bench for hilo_register: scoreboard of expected captures and
// reads, checked with immediate assertions.
module tb_hilo_register;

  localparam int MUL_CYCLES = 32;
  localparam logic [2:0] SIG_MUL  = 3'b100;
  localparam logic [2:0] SIG_MFHI = 3'b101;
  localparam logic [2:0] SIG_MFLO = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  signal;
  logic [63:0] dataIn;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic [31:0] dataOut;
  logic        busy;
  logic        valid;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  sb_t         sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_dout;

  hilo_register #(
    .MUL_CYCLES (MUL_CYCLES),
    .SIG_MUL    (SIG_MUL),
    .SIG_MFHI   (SIG_MFHI),
    .SIG_MFLO   (SIG_MFLO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .dataIn  (dataIn),
    .hiOut   (hiOut),
    .loOut   (loOut),
    .dataOut (dataOut),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    sb_t e;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input logic [2:0] code,
                    input string tag,
                    input logic [31:0] exp);
    signal = code;
    push(tag, {32'd0, exp});
    step();
    pop_chk({32'd0, dataOut});
    exp_dout = exp;
    signal = 3'b000;
  endtask

  // Starts a multiply, optionally holds the code or injects another code
  // mid-wait, and checks busy length, capture edge and captured value.
  task automatic mul_run(input logic [63:0] prod,
                         input int hold,
                         input logic [2:0] mid_sig,
                         input int mid_at);
    int nbusy;
    int cap_at;
    int last;
    nbusy  = 0;
    cap_at = -1;
    last   = ((hold > MUL_CYCLES) ? hold : MUL_CYCLES) + 4;
    signal = SIG_MUL;
    dataIn = {$urandom, $urandom};
    push("capture", prod);
    step();
    if (busy) nbusy++;
    for (int i = 1; i <= last; i++) begin
      signal = (i < hold) ? SIG_MUL : 3'b000;
      if (i == mid_at) signal = mid_sig;
      dataIn = (i == MUL_CYCLES) ? prod : {$urandom, $urandom};
      step();
      if (i == mid_at) chk("read_in_wait", {32'd0, dataOut}, {32'd0, exp_dout});
      if (busy) nbusy++;
      else if (cap_at < 0) begin
        cap_at = i;
        pop_chk({hiOut, loOut});
      end
    end
    chk("busy_cycles", 64'(nbusy), 64'(MUL_CYCLES));
    chk("capture_edge", 64'(cap_at), 64'(MUL_CYCLES));
    chk("valid_after", {63'd0, valid}, 64'd1);
  endtask

  initial begin
    int nb;
    logic [63:0] p3;
    logic [63:0] p4;
    logic [63:0] p5;

    // Reset with random inputs
    rst    = 1'b1;
    signal = 3'($urandom_range(0, 7));
    dataIn = {$urandom, $urandom};
    step();
    signal = SIG_MUL;
    dataIn = {$urandom, $urandom};
    step();
    chk("rst_hi",    {32'd0, hiOut},   64'd0);
    chk("rst_lo",    {32'd0, loOut},   64'd0);
    chk("rst_dout",  {32'd0, dataOut}, 64'd0);
    chk("rst_busy",  {63'd0, busy},    64'd0);
    chk("rst_valid", {63'd0, valid},   64'd0);
    rst      = 1'b0;
    signal   = 3'b000;
    exp_dout = 32'd0;
    step();

    // Single-cycle multiply pulse
    mul_run(64'h0000_0001_FFFF_FFFE, 1, 3'b000, -1);
    chk("hi_t2", {32'd0, hiOut}, 64'h1);
    chk("lo_t2", {32'd0, loOut}, 64'hFFFF_FFFE);

    // Reads, one cycle latency
    rd(SIG_MFHI, "mfhi_t3", 32'h0000_0001);
    rd(SIG_MFLO, "mflo_t3", 32'hFFFF_FFFE);
    step();
    chk("dout_hold", {32'd0, dataOut}, 64'hFFFF_FFFE);

    // Multiply code held for 40 cycles: one capture only
    p3 = 64'h1234_5678_9ABC_DEF0;
    mul_run(p3, 40, 3'b000, -1);
    chk("hi_t4", {32'd0, hiOut}, {32'd0, p3[63:32]});

    // Restart at cnt=10
    p4 = 64'hCAFE_F00D_0BAD_BEEF;
    signal = SIG_MUL;
    dataIn = {$urandom, $urandom};
    step();
    signal = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      dataIn = {$urandom, $urandom};
      step();
    end
    chk("busy_pre_restart", {63'd0, busy}, 64'd1);
    chk("hilo_pre_restart", {hiOut, loOut}, p3);
    mul_run(p4, 1, 3'b000, -1);
    rd(SIG_MFHI, "mfhi_t5", p4[63:32]);
    rd(SIG_MFLO, "mflo_t5", p4[31:0]);

    // Read during WAIT is ignored, capture timing unchanged
    p5 = 64'h0F0F_0F0F_F0F0_F0F0;
    mul_run(p5, 1, SIG_MFLO, 15);
    chk("dout_after_wait", {32'd0, dataOut}, {32'd0, exp_dout});

    // Reset at cnt=20 discards the multiply
    signal = SIG_MUL;
    step();
    signal = 3'b000;
    for (int i = 1; i <= 20; i++) begin
      dataIn = {$urandom, $urandom};
      step();
    end
    rst    = 1'b1;
    signal = SIG_MUL;
    step();
    chk("rst_wait_busy",  {63'd0, busy},    64'd0);
    chk("rst_wait_valid", {63'd0, valid},   64'd0);
    chk("rst_wait_hilo",  {hiOut, loOut},   64'd0);
    chk("rst_wait_dout",  {32'd0, dataOut}, 64'd0);
    rst      = 1'b0;
    signal   = 3'b000;
    exp_dout = 32'd0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      dataIn = {$urandom, $urandom};
      step();
      if (busy || valid) nb++;
    end
    chk("idle_after_rst", 64'(nb), 64'd0);
    rd(SIG_MFHI, "mfhi_rst", 32'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
